csr_host_initiator: RTL and testbench

- Avalon-MM initiator that issues single-beat CSR reads/writes toward the config-timeout CSR block's responder port (HIP status, timeout, clock freq, soft reset, error status).
- Accepts commands from a local sequencer over a valid/ready command channel, and returns a response on a valid/ready response channel.
- Runs a per-transaction watchdog and flags hung accesses.
- Sits between the debug/sequencer logic and the CSR responder in the same clock domain.

---
 rtl/csr_host_pkg.sv | 22 ++
 rtl/csr_host_watchdog.sv | 58 +++++
 rtl/csr_host_initiator.sv | 207 ++++++++++++++++++++
 tb/tb_csr_host_initiator.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_host_pkg.sv
// Shared types and constants for the CSR host initiator and its users.
// Holds the FSM state encoding, response status codes and responder register offsets.
package csr_host_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        RDWAIT = 2'b10,
        RESP   = 2'b11
    } host_state_e;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_TIMEOUT = 2'b01;

    // Byte offsets of the config-timeout CSR block
    localparam logic [7:0] HIP_STATUS  = 8'h00;
    localparam logic [7:0] TIMEOUT_REG = 8'h04;
    localparam logic [7:0] CLOCK_FREQ  = 8'h08;
    localparam logic [7:0] SOFT_RESET  = 8'h0C;
    localparam logic [7:0] ERROR_STAT  = 8'h10;

endpackage

// File: rtl/csr_host_watchdog.sv
// Per-transaction watchdog: saturating cycle counter, live limit compare and expiry pulse.
// A limit of zero disables expiry; completion in the expiry cycle suppresses it.
module csr_host_watchdog #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 done_i,
    input  logic [REG_WIDTH-1:0] limit_i,
    output logic                 expire_o,
    output logic                 pulse_o
);

    localparam logic [REG_WIDTH-1:0] CNT_ZERO = {REG_WIDTH{1'b0}};
    localparam logic [REG_WIDTH-1:0] CNT_ONES = {REG_WIDTH{1'b1}};
    localparam logic [REG_WIDTH-1:0] CNT_ONE  = {{(REG_WIDTH-1){1'b0}}, 1'b1};

    logic [REG_WIDTH-1:0] count_r;
    logic [REG_WIDTH-1:0] count_nxt_s;
    logic                 hit_s;
    logic                 pulse_r;

    // Limit compare and next counter value
    always_comb begin
        hit_s       = 1'b0;
        count_nxt_s = count_r;
        // >= so that lowering the limit mid-transaction still fires at once
        if (enable_i && (limit_i != CNT_ZERO) && (count_r >= (limit_i - CNT_ONE))) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        if (clear_i) begin
            count_nxt_s = CNT_ZERO;
        end else if (enable_i && (count_r != CNT_ONES)) begin
            count_nxt_s = count_r + CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    assign expire_o = hit_s & ~done_i;
    assign pulse_o  = pulse_r;

    // Counter and one-cycle expiry pulse registers
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            count_r <= CNT_ZERO;
            pulse_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            pulse_r <= expire_o;
        end
    end

endmodule

// File: rtl/csr_host_initiator.sv
// Avalon-MM single-beat CSR initiator fed by a valid/ready command channel.
// One outstanding command; responses return on a valid/ready channel with OK/TIMEOUT status.
module csr_host_initiator
    import csr_host_pkg::*;
#(
    parameter int CSR_ADDR_WIDTH = 8,
    parameter int CSR_DATA_WIDTH = 32,
    parameter int REG_WIDTH      = 32
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_write_i,
    input  logic [CSR_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [CSR_DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [CSR_DATA_WIDTH/8-1:0] cmd_be_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [CSR_DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]                  rsp_status_o,
    input  logic [REG_WIDTH-1:0]        timeout_cycles_i,
    output logic                        timeout_o,
    output logic [CSR_ADDR_WIDTH-1:0]   avm_address_o,
    output logic                        avm_read_o,
    output logic                        avm_write_o,
    output logic [CSR_DATA_WIDTH-1:0]   avm_writedata_o,
    output logic [CSR_DATA_WIDTH/8-1:0] avm_byteenable_o,
    output logic                        avm_burstcount_o,
    output logic                        avm_debugaccess_o,
    input  logic                        avm_waitrequest_i,
    input  logic                        avm_readdatavalid_i,
    input  logic [CSR_DATA_WIDTH-1:0]   avm_readdata_i
);

    localparam int BE_WIDTH = CSR_DATA_WIDTH / 8;

    host_state_e                 state_r,       state_nxt_s;
    logic [CSR_ADDR_WIDTH-1:0]   addr_r,        addr_nxt_s;
    logic [CSR_DATA_WIDTH-1:0]   wdata_r,       wdata_nxt_s;
    logic [BE_WIDTH-1:0]         be_r,          be_nxt_s;
    logic                        dir_write_r,   dir_write_nxt_s;
    logic                        avm_read_r,    avm_read_nxt_s;
    logic                        avm_write_r,   avm_write_nxt_s;
    logic                        cmd_ready_r,   cmd_ready_nxt_s;
    logic                        rsp_valid_r,   rsp_valid_nxt_s;
    logic [CSR_DATA_WIDTH-1:0]   rsp_rdata_r,   rsp_rdata_nxt_s;
    logic [1:0]                  rsp_status_r,  rsp_status_nxt_s;

    logic wd_clear_s;
    logic wd_enable_s;
    logic wd_done_s;
    logic wd_expire_s;
    logic wd_pulse_s;

    assign wd_clear_s  = (state_r == IDLE) & cmd_valid_i & cmd_ready_r;
    assign wd_enable_s = (state_r == REQ) | (state_r == RDWAIT);
    assign wd_done_s   = ((state_r == REQ) & ~avm_waitrequest_i)
                       | ((state_r == RDWAIT) & avm_readdatavalid_i);

    csr_host_watchdog #(
        .REG_WIDTH (REG_WIDTH)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clear_i  (wd_clear_s),
        .enable_i (wd_enable_s),
        .done_i   (wd_done_s),
        .limit_i  (timeout_cycles_i),
        .expire_o (wd_expire_s),
        .pulse_o  (wd_pulse_s)
    );

    // Next-state and next registered-output logic
    always_comb begin
        state_nxt_s      = state_r;
        addr_nxt_s       = addr_r;
        wdata_nxt_s      = wdata_r;
        be_nxt_s         = be_r;
        dir_write_nxt_s  = dir_write_r;
        avm_read_nxt_s   = avm_read_r;
        avm_write_nxt_s  = avm_write_r;
        rsp_valid_nxt_s  = rsp_valid_r;
        rsp_rdata_nxt_s  = rsp_rdata_r;
        rsp_status_nxt_s = rsp_status_r;

        case (state_r)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_r) begin
                    state_nxt_s     = REQ;
                    addr_nxt_s      = cmd_addr_i;
                    wdata_nxt_s     = cmd_wdata_i;
                    be_nxt_s        = cmd_be_i;
                    dir_write_nxt_s = cmd_write_i;
                    avm_read_nxt_s  = ~cmd_write_i;
                    avm_write_nxt_s = cmd_write_i;
                end else begin
                    avm_read_nxt_s  = 1'b0;
                    avm_write_nxt_s = 1'b0;
                end
            end
            REQ: begin
                if (!avm_waitrequest_i) begin
                    avm_read_nxt_s  = 1'b0;
                    avm_write_nxt_s = 1'b0;
                    if (dir_write_r) begin
                        state_nxt_s      = RESP;
                        rsp_valid_nxt_s  = 1'b1;
                        rsp_rdata_nxt_s  = {CSR_DATA_WIDTH{1'b0}};
                        rsp_status_nxt_s = RSP_OK;
                    end else if (avm_readdatavalid_i) begin
                        // data returned in the acceptance cycle itself
                        state_nxt_s      = RESP;
                        rsp_valid_nxt_s  = 1'b1;
                        rsp_rdata_nxt_s  = avm_readdata_i;
                        rsp_status_nxt_s = RSP_OK;
                    end else begin
                        state_nxt_s = RDWAIT;
                    end
                end else if (wd_expire_s) begin
                    avm_read_nxt_s   = 1'b0;
                    avm_write_nxt_s  = 1'b0;
                    state_nxt_s      = RESP;
                    rsp_valid_nxt_s  = 1'b1;
                    rsp_rdata_nxt_s  = {CSR_DATA_WIDTH{1'b0}};
                    rsp_status_nxt_s = RSP_TIMEOUT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            RDWAIT: begin
                if (avm_readdatavalid_i) begin
                    state_nxt_s      = RESP;
                    rsp_valid_nxt_s  = 1'b1;
                    rsp_rdata_nxt_s  = avm_readdata_i;
                    rsp_status_nxt_s = RSP_OK;
                end else if (wd_expire_s) begin
                    state_nxt_s      = RESP;
                    rsp_valid_nxt_s  = 1'b1;
                    rsp_rdata_nxt_s  = {CSR_DATA_WIDTH{1'b0}};
                    rsp_status_nxt_s = RSP_TIMEOUT;
                end else begin
                    state_nxt_s = RDWAIT;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt_s     = IDLE;
                    rsp_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                avm_read_nxt_s  = 1'b0;
                avm_write_nxt_s = 1'b0;
                rsp_valid_nxt_s = 1'b0;
            end
        endcase

        cmd_ready_nxt_s = (state_nxt_s == IDLE);
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r      <= IDLE;
            addr_r       <= {CSR_ADDR_WIDTH{1'b0}};
            wdata_r      <= {CSR_DATA_WIDTH{1'b0}};
            be_r         <= {BE_WIDTH{1'b0}};
            dir_write_r  <= 1'b0;
            avm_read_r   <= 1'b0;
            avm_write_r  <= 1'b0;
            cmd_ready_r  <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= {CSR_DATA_WIDTH{1'b0}};
            rsp_status_r <= RSP_OK;
        end else begin
            state_r      <= state_nxt_s;
            addr_r       <= addr_nxt_s;
            wdata_r      <= wdata_nxt_s;
            be_r         <= be_nxt_s;
            dir_write_r  <= dir_write_nxt_s;
            avm_read_r   <= avm_read_nxt_s;
            avm_write_r  <= avm_write_nxt_s;
            cmd_ready_r  <= cmd_ready_nxt_s;
            rsp_valid_r  <= rsp_valid_nxt_s;
            rsp_rdata_r  <= rsp_rdata_nxt_s;
            rsp_status_r <= rsp_status_nxt_s;
        end
    end

    assign cmd_ready_o       = cmd_ready_r;
    assign rsp_valid_o       = rsp_valid_r;
    assign rsp_rdata_o       = rsp_rdata_r;
    assign rsp_status_o      = rsp_status_r;
    assign timeout_o         = wd_pulse_s;
    assign avm_address_o     = addr_r;
    assign avm_read_o        = avm_read_r;
    assign avm_write_o       = avm_write_r;
    assign avm_writedata_o   = wdata_r;
    assign avm_byteenable_o  = be_r;
    assign avm_burstcount_o  = 1'b1;
    assign avm_debugaccess_o = 1'b0;

endmodule

// File: tb/tb_csr_host_initiator.sv
// Directed bench for csr_host_initiator with a behavioural CSR responder and response scoreboard.
// Expected responses are queued when a command is issued and popped when the DUT responds.
module tb_csr_host_initiator;
    import csr_host_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  status;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [7:0]  cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_be_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_status_o;
    logic [31:0] timeout_cycles_i;
    logic        timeout_o;
    logic [7:0]  avm_address_o;
    logic        avm_read_o;
    logic        avm_write_o;
    logic [31:0] avm_writedata_o;
    logic [3:0]  avm_byteenable_o;
    logic        avm_burstcount_o;
    logic        avm_debugaccess_o;
    logic        avm_waitrequest_i;
    logic        avm_readdatavalid_i;
    logic [31:0] avm_readdata_i;

    csr_host_initiator dut (
        .clk_i               (clk_i),
        .rstn_i              (rstn_i),
        .cmd_valid_i         (cmd_valid_i),
        .cmd_ready_o         (cmd_ready_o),
        .cmd_write_i         (cmd_write_i),
        .cmd_addr_i          (cmd_addr_i),
        .cmd_wdata_i         (cmd_wdata_i),
        .cmd_be_i            (cmd_be_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsp_ready_i),
        .rsp_rdata_o         (rsp_rdata_o),
        .rsp_status_o        (rsp_status_o),
        .timeout_cycles_i    (timeout_cycles_i),
        .timeout_o           (timeout_o),
        .avm_address_o       (avm_address_o),
        .avm_read_o          (avm_read_o),
        .avm_write_o         (avm_write_o),
        .avm_writedata_o     (avm_writedata_o),
        .avm_byteenable_o    (avm_byteenable_o),
        .avm_burstcount_o    (avm_burstcount_o),
        .avm_debugaccess_o   (avm_debugaccess_o),
        .avm_waitrequest_i   (avm_waitrequest_i),
        .avm_readdatavalid_i (avm_readdatavalid_i),
        .avm_readdata_i      (avm_readdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Responder controls driven by the stimulus
    int          wait_len   = 1;
    logic        rdv_en     = 1'b1;
    logic        stray_rdv  = 1'b0;
    logic        linkup     = 1'b0;
    logic        dl_up      = 1'b0;
    logic [4:0]  ltssm      = 5'h00;

    logic [31:0] regs [0:7];
    int          wait_cnt   = 0;
    logic        rdv_r      = 1'b0;
    logic [31:0] rd_data_r  = 32'h0;

    function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    assign avm_waitrequest_i   = (avm_read_o | avm_write_o) && (wait_cnt < wait_len);
    assign avm_readdatavalid_i = rdv_r | stray_rdv;
    assign avm_readdata_i      = rd_data_r;

    // Behavioural responder: wait-state counter, register file, one-cycle read latency
    always @(posedge clk_i) begin
        if (avm_read_o | avm_write_o) wait_cnt <= wait_cnt + 1;
        else                          wait_cnt <= 0;
        rdv_r <= 1'b0;
        if (avm_write_o && !avm_waitrequest_i)
            regs[avm_address_o[4:2]] <= merge_be(regs[avm_address_o[4:2]], avm_writedata_o, avm_byteenable_o);
        if (avm_read_o && !avm_waitrequest_i && rdv_en) begin
            rdv_r <= 1'b1;
            if (avm_address_o == HIP_STATUS) rd_data_r <= {23'h0, ltssm, 2'b00, dl_up, linkup};
            else                             rd_data_r <= regs[avm_address_o[4:2]];
        end
    end

    // Strobe / pulse monitor, cumulative so the stimulus only takes differences
    int   rd_run = 0, wr_run = 0, last_rd_run = 0, last_wr_run = 0;
    int   rises = 0, age = 0, to_cnt = 0, to_age = 0;
    logic prev_strobe = 1'b0;
    always @(negedge clk_i) begin
        prev_strobe <= avm_read_o | avm_write_o;
        if (avm_read_o) rd_run <= rd_run + 1;
        else begin
            if (rd_run != 0) last_rd_run <= rd_run;
            rd_run <= 0;
        end
        if (avm_write_o) wr_run <= wr_run + 1;
        else begin
            if (wr_run != 0) last_wr_run <= wr_run;
            wr_run <= 0;
        end
        if ((avm_read_o | avm_write_o) && !prev_strobe) begin
            rises <= rises + 1;
            age   <= 1;
        end else begin
            age <= age + 1;
        end
        if (timeout_o) begin
            to_cnt <= to_cnt + 1;
            to_age <= age;
        end
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   snap_to, snap_rises;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_status, input bit push);
        exp_t e;
        e.rdata  = exp_rdata;
        e.status = exp_status;
        if (push) exp_q.push_back(e);
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_be_i    = be;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 200 && !cmd_ready_o; i++) @(negedge clk_i);
        check("cmd_accept", {31'h0, cmd_ready_o}, 32'h1);
        @(negedge clk_i);
    endtask

    task automatic wait_rsp(input int budget);
        exp_t e;
        for (int i = 0; i < budget && !rsp_valid_o; i++) @(negedge clk_i);
        check("rsp_valid", {31'h0, rsp_valid_o}, 32'h1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata_o, e.rdata);
            check("rsp_status", {30'h0, rsp_status_o}, {30'h0, e.status});
        end else begin
            check("scoreboard_nonempty", exp_q.size(), 32'h1);
        end
        @(negedge clk_i);
    endtask

    initial begin
        rstn_i           = 1'b0;
        cmd_valid_i      = 1'b0;
        cmd_write_i      = 1'b0;
        cmd_addr_i       = 8'h00;
        cmd_wdata_i      = 32'h0;
        cmd_be_i         = 4'h0;
        rsp_ready_i      = 1'b1;
        timeout_cycles_i = 32'd64;
        repeat (3) @(negedge clk_i);

        // Reset values
        check("rst_cmd_ready", {31'h0, cmd_ready_o}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        check("rst_avm_read", {31'h0, avm_read_o}, 32'h0);
        check("rst_avm_write", {31'h0, avm_write_o}, 32'h0);
        check("rst_burstcount", {31'h0, avm_burstcount_o}, 32'h1);
        check("rst_debugaccess", {31'h0, avm_debugaccess_o}, 32'h0);
        check("rst_timeout", {31'h0, timeout_o}, 32'h0);
        check("rst_rdata", rsp_rdata_o, 32'h0);
        check("rst_status", {30'h0, rsp_status_o}, 32'h0);
        rstn_i = 1'b1;
        @(negedge clk_i);
        check("idle_cmd_ready", {31'h0, cmd_ready_o}, 32'h1);

        // Write then read back TIMEOUT_REG
        issue(1'b1, TIMEOUT_REG, 32'h0000_1234, 4'hF, 32'h0, RSP_OK, 1'b1);
        cmd_valid_i = 1'b0;
        wait_rsp(50);
        check("write_strobe_len", last_wr_run, 32'd2);
        issue(1'b0, TIMEOUT_REG, 32'h0, 4'hF, 32'h0000_1234, RSP_OK, 1'b1);
        cmd_valid_i = 1'b0;
        wait_rsp(50);
        check("read_strobe_len", last_rd_run, 32'd2);

        // HIP status read
        linkup = 1'b1; dl_up = 1'b1; ltssm = 5'h11;
        issue(1'b0, HIP_STATUS, 32'h0, 4'hF, 32'h0000_0113, RSP_OK, 1'b1);
        cmd_valid_i = 1'b0;
        wait_rsp(50);
        check("hip_strobe_len", last_rd_run, 32'd2);

        // Watchdog expiry with waitrequest stuck high
        timeout_cycles_i = 32'd8;
        wait_len = 1000;
        snap_to = to_cnt;
        issue(1'b0, CLOCK_FREQ, 32'h0, 4'hF, 32'h0, RSP_TIMEOUT, 1'b1);
        cmd_valid_i = 1'b0;
        wait_rsp(50);
        check("to_req_strobe_len", last_rd_run, 32'd8);
        check("to_req_pulses", to_cnt - snap_to, 32'd1);
        check("to_req_age", to_age, 32'd8);

        // Watchdog expiry while waiting for readdatavalid
        wait_len = 1;
        rdv_en = 1'b0;
        snap_to = to_cnt;
        issue(1'b0, ERROR_STAT, 32'h0, 4'hF, 32'h0, RSP_TIMEOUT, 1'b1);
        cmd_valid_i = 1'b0;
        wait_rsp(50);
        check("to_rdw_strobe_len", last_rd_run, 32'd2);
        check("to_rdw_pulses", to_cnt - snap_to, 32'd1);
        check("to_rdw_age", to_age, 32'd8);

        // Stray readdatavalid in IDLE is ignored
        rdv_en = 1'b1;
        stray_rdv = 1'b1;
        @(negedge clk_i);
        stray_rdv = 1'b0;
        repeat (2) @(negedge clk_i);
        check("stray_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        check("stray_cmd_ready", {31'h0, cmd_ready_o}, 32'h1);

        // Completion in the expiry cycle wins
        timeout_cycles_i = 32'd2;
        snap_to = to_cnt;
        issue(1'b1, SOFT_RESET, 32'h0000_005A, 4'h1, 32'h0, RSP_OK, 1'b1);
        cmd_valid_i = 1'b0;
        wait_rsp(50);
        check("tie_pulses", to_cnt - snap_to, 32'd0);
        timeout_cycles_i = 32'd64;

        // Back-to-back with cmd_valid held
        snap_rises = rises;
        issue(1'b1, SOFT_RESET, 32'hA5A5_0001, 4'hF, 32'h0, RSP_OK, 1'b1);
        wait_rsp(50);
        issue(1'b0, SOFT_RESET, 32'h0, 4'hF, 32'hA5A5_0001, RSP_OK, 1'b1);
        cmd_valid_i = 1'b0;
        wait_rsp(50);
        check("b2b_strobe_rises", rises - snap_rises, 32'd2);

        // Response backpressure
        rsp_ready_i = 1'b0;
        issue(1'b0, TIMEOUT_REG, 32'h0, 4'hF, 32'h0000_1234, RSP_OK, 1'b1);
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 50 && !rsp_valid_o; i++) @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'h0, rsp_valid_o}, 32'h1);
            check("bp_rdata", rsp_rdata_o, 32'h0000_1234);
            check("bp_status", {30'h0, rsp_status_o}, 32'h0);
            check("bp_cmd_ready", {31'h0, cmd_ready_o}, 32'h0);
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b1;
        wait_rsp(10);

        // Watchdog disabled, long waitrequest
        timeout_cycles_i = 32'd0;
        wait_len = 1000;
        snap_to = to_cnt;
        issue(1'b1, TIMEOUT_REG, 32'h0000_BEEF, 4'hF, 32'h0, RSP_OK, 1'b1);
        cmd_valid_i = 1'b0;
        wait_rsp(2000);
        check("nowd_pulses", to_cnt - snap_to, 32'd0);
        check("nowd_strobe_len", last_wr_run, 32'd1001);

        // Reset asserted during REQ
        issue(1'b1, SOFT_RESET, 32'h1111_2222, 4'hF, 32'h0, RSP_OK, 1'b0);
        cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("req_write_high", {31'h0, avm_write_o}, 32'h1);
        rstn_i = 1'b0;
        @(negedge clk_i);
        check("midrst_write", {31'h0, avm_write_o}, 32'h0);
        check("midrst_read", {31'h0, avm_read_o}, 32'h0);
        check("midrst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        check("midrst_cmd_ready", {31'h0, cmd_ready_o}, 32'h0);
        rstn_i = 1'b1;
        wait_len = 1;
        @(negedge clk_i);
        check("post_rst_idle", {31'h0, cmd_ready_o}, 32'h1);
        issue(1'b0, TIMEOUT_REG, 32'h0, 4'hF, 32'h0000_BEEF, RSP_OK, 1'b1);
        cmd_valid_i = 1'b0;
        wait_rsp(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
